// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative shift-add multiply / restoring divide unit owning the HI/LO pair
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} stateT;
  localparam logic [2:0] OP_MADD = 3'd4;
  localparam logic [2:0] OP_MSUB = 3'd5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  stateT state, nextState;
  logic [2:0] opReg;
  logic [WIDTH-1:0] aReg, bReg, mcand, hi, lo, magA, magB, quo, rem;
  logic [2*WIDTH-1:0] prod, prodSigned, result;
  logic [WIDTH:0] addSum, shifted, diff;
  logic [CNT_W-1:0] cnt;
  logic negRes, negRem, divZ, accept, isDiv, isSigned, commit;
  assign accept = Start && (Op <= 3'd5) && !Flush && (state == IDLE || state == DONE);
  assign isDiv = opReg[2:1] == 2'b01;
  assign isSigned = !opReg[0] || opReg[2];
  assign magA = (isSigned && aReg[WIDTH-1]) ? -aReg : aReg;
  assign magB = (isSigned && bReg[WIDTH-1]) ? -bReg : bReg;
  // prod doubles as {partial product, multiplier} or {remainder, quotient}
  assign addSum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign shifted = prod[2*WIDTH-1:WIDTH-1];
  assign diff = shifted - {1'b0, mcand};
  assign quo = negRes ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
  assign rem = negRem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
  assign prodSigned = negRes ? -prod : prod;
  assign result = isDiv ? {rem, quo} :
                  opReg == OP_MADD ? {hi, lo} + prodSigned :
                  opReg == OP_MSUB ? {hi, lo} - prodSigned : prodSigned;
  assign commit = state == FIX && !Flush && !divZ;
  assign Busy = state == PREP || state == ITER || state == FIX;
  assign Done = state == DONE;
  assign DivZero = state == DONE && divZ;
  assign HiOut = hi;
  assign LoOut = lo;
  always_comb begin
    nextState = state;
    if (Flush) nextState = IDLE;
    else if (accept) nextState = PREP;
    else if (state == PREP) nextState = ITER;
    else if (state == ITER && cnt == LAST_CNT) nextState = FIX;
    else if (state == FIX) nextState = DONE;
    else if (state == DONE) nextState = IDLE;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      opReg <= '0;
      aReg <= '0;
      bReg <= '0;
      mcand <= '0;
      prod <= '0;
      cnt <= '0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      divZ <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (accept) {opReg, aReg, bReg} <= {Op, OperandA, OperandB};
      if (state == PREP) begin
        prod <= {{WIDTH{1'b0}}, isDiv ? magA : magB};
        mcand <= isDiv ? magB : magA;
        negRes <= isSigned && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
        negRem <= isSigned && aReg[WIDTH-1];
        divZ <= isDiv && bReg == '0;
        cnt <= '0;
      end
      if (state == ITER) begin
        prod <= isDiv ? {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], prod[WIDTH-2:0], !diff[WIDTH]}
                      : {addSum, prod[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end
      if (HiWrite) hi <= WriteData;
      if (LoWrite) lo <= WriteData;
      if (commit) {hi, lo} <= result;
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench with an arithmetic reference model for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  localparam int W = 32;
  logic Clk = 0, Rst, Start = 0, Flush = 0, HiWrite = 0, LoWrite = 0;
  logic [2:0] Op = 0;
  logic [W-1:0] OperandA = 0, OperandB = 0, WriteData = 0;
  logic Busy, Done, DivZero;
  logic [W-1:0] HiOut, LoOut;
  int checks = 0, failures = 0;
  logic [64:0] expQ[$];
  logic [64:0] monE;
  logic [W-1:0] mHi = 0, mLo = 0;

  hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OperandA(OperandA), .OperandB(OperandB),
    .Flush(Flush), .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {DivZero, HI, LO} after the operation, from plain integer arithmetic
  function automatic logic [64:0] model(input logic [2:0] op, input logic [W-1:0] a, b, hi, lo);
    longint sa, sb, q, r;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    acc = {hi, lo};
    case (op)
      3'd0: return {1'b0, 64'(sa * sb)};
      3'd1: return {1'b0, {32'b0, a} * {32'b0, b}};
      3'd2: begin
        if (b == 0) return {1'b1, hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: return (b == 0) ? {1'b1, hi, lo} : {1'b0, a % b, a / b};
      3'd4: return {1'b0, acc + 64'(sa * sb)};
      3'd5: return {1'b0, acc - 64'(sa * sb)};
      default: return {1'b0, hi, lo};
    endcase
  endfunction

  always @(negedge Clk) if (Rst) begin
    if (Done) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=Done required=no_Done");
      end else begin
        monE = expQ.pop_front();
        chk("result", {DivZero, HiOut, LoOut}, monE);
      end
    end else if (DivZero) begin
      checks++;
      failures++;
      $display("FAIL divzero_outside_done actual=1 required=0");
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, input bit push);
    logic [64:0] r;
    Start = 1;
    Op = op;
    OperandA = a;
    OperandB = b;
    if (push) begin
      r = model(op, a, b, mHi, mLo);
      expQ.push_back(r);
      {mHi, mLo} = r[63:0];
    end
    @(negedge Clk);
    Start = 0;
  endtask

  task automatic waitDone(input int n0, input string tag);
    int n = n0;
    bit busyOk = 1;
    while (!Done && n < 100) begin
      if (!Busy) busyOk = 0;
      @(negedge Clk);
      n++;
    end
    chk({tag, "_latency"}, n, W + 2);
    chk({tag, "_busy_during_op"}, busyOk, 1);
    chk({tag, "_busy_low_in_done"}, Busy, 0);
  endtask

  task automatic mt(input bit selHi, input logic [W-1:0] d);
    HiWrite = selHi;
    LoWrite = !selHi;
    WriteData = d;
    if (selHi) mHi = d;
    else mLo = d;
    @(negedge Clk);
    HiWrite = 0;
    LoWrite = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b, wv;
    logic [2:0] op;
    Rst = 1;
    #1 Rst = 0;
    #1 chk("reset_state", {Busy, Done, DivZero, HiOut, LoOut}, 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    issue(3'd0, 32'hFFFFFFFD, 32'd5, 1);
    waitDone(0, "mult");
    chk("mult_hilo", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFF1);
    @(negedge Clk);
    chk("done_one_cycle", Done, 0);
    issue(3'd3, 32'd100, 32'd7, 1);
    waitDone(0, "divu");
    chk("divu_hilo", {HiOut, LoOut}, {32'd2, 32'd14});
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1);
    waitDone(0, "div_b2b");
    chk("div_b2b_hilo", {HiOut, LoOut}, 64'hFFFFFFFF_FFFFFFFD);
    @(negedge Clk);
    mt(1, 32'd0);
    mt(0, 32'hFFFFFFFF);
    issue(3'd4, 32'd1, 32'd1, 1);
    waitDone(0, "madd");
    chk("madd_hilo", {HiOut, LoOut}, {32'd1, 32'd0});
    @(negedge Clk);
    issue(3'd5, 32'd1, 32'd1, 1);
    waitDone(0, "msub");
    chk("msub_hilo", {HiOut, LoOut}, {32'd0, 32'hFFFFFFFF});
    @(negedge Clk);
    mt(1, 32'h1234);
    mt(0, 32'h5678);
    issue(3'd2, 32'd5, 32'd0, 1);
    waitDone(0, "div0");
    chk("div0_flag", DivZero, 1);
    chk("div0_hilo_kept", {HiOut, LoOut}, {32'h1234, 32'h5678});
    @(negedge Clk);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1);
    waitDone(0, "div_min");
    chk("div_min_hilo", {DivZero, HiOut, LoOut}, {1'b0, 32'd0, 32'h80000000});
    @(negedge Clk);
    issue(3'd1, $urandom, $urandom, 1);
    repeat (4) @(negedge Clk);
    issue(3'd3, $urandom, $urandom, 0);
    waitDone(5, "ignored_start");
    @(negedge Clk);
    issue(3'd1, $urandom, $urandom, 0);
    repeat (4) @(negedge Clk);
    issue(3'd0, $urandom, $urandom, 0);
    repeat (5) @(negedge Clk);
    Flush = 1;
    @(negedge Clk);
    Flush = 0;
    chk("flush_busy", Busy, 0);
    chk("flush_hilo_kept", {HiOut, LoOut}, {mHi, mLo});
    repeat (40) @(negedge Clk);
    chk("flush_still_idle", {Busy, Done}, 0);
    issue(3'd6, 32'd3, 32'd4, 0);
    chk("reserved_op_idle", Busy, 0);
    issue(3'd7, 32'd3, 32'd4, 0);
    chk("reserved_op7_idle", Busy, 0);
    issue(3'd0, $urandom, $urandom, 1);
    repeat (33) @(negedge Clk);
    HiWrite = 1;
    WriteData = 32'hDEAD;
    @(negedge Clk);
    HiWrite = 0;
    waitDone(34, "write_vs_result");
    @(negedge Clk);
    wv = $urandom;
    mLo = wv;
    issue(3'd4, $urandom, $urandom, 1);
    repeat (10) @(negedge Clk);
    LoWrite = 1;
    WriteData = wv;
    @(negedge Clk);
    LoWrite = 0;
    waitDone(11, "madd_iter_write");
    @(negedge Clk);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      issue(op, a, b, 1);
      waitDone(0, "rand");
      if ($urandom_range(0, 1) == 0) @(negedge Clk);
    end
    @(negedge Clk);
    issue(3'd0, $urandom, $urandom, 1);
    repeat (15) @(negedge Clk);
    #2 Rst = 0;
    #1 chk("async_reset_outputs", {Busy, Done, DivZero, HiOut, LoOut}, 0);
    expQ.delete();
    mHi = 0;
    mLo = 0;
    @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    issue(3'd0, 32'd6, 32'd7, 1);
    waitDone(0, "post_reset");
    chk("post_reset_lo", LoOut, 32'd42);
    @(negedge Clk);
    chk("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
